// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and function code in, result flags out.
// Purely structural, no latency of its own.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, ctl, a, b, cin, out_ready,
        input  in_ready, out_valid, result, hi, carry, zero
    );

    modport slave (
        input  in_valid, ctl, a, b, cin, out_ready,
        output in_ready, out_valid, result, hi, carry, zero
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle WIDTH-bit integer ALU: registered logic/arith ops, iterative multu and (optional) divu.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH+1 cycles for multu/divu.
// Backpressure: accepts only in IDLE; result held in DONE until out_ready. Macro SEQ_ALU_DIV_EN enables divu.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef SEQ_ALU_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             slt_ovf;
    logic [WIDTH:0]   mul_sum;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
`endif

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = (result_q == '0);

    // Next-state and datapath: capture on accept, then one mul/div step per cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        b_d      = b_q;
        carry_d  = carry_q;

        add_sum = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
        sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        // Signed overflow of a-b: operands differ in sign and difference sign differs from a.
        slt_ovf = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (sub_sum[WIDTH-1] ^ bus.a[WIDTH-1]);

        // Shift-add: low multiplier bit sits in result_q[0], partial product in hi_q.
        mul_sum = {1'b0, hi_q} + (result_q[0] ? {1'b0, b_q} : '0);
`ifdef SEQ_ALU_DIV_EN
        // Restoring step: shift next dividend bit into the remainder and try to subtract.
        rem_sh  = {hi_q, result_q[WIDTH-1]};
        div_ge  = (rem_sh >= {1'b0, b_q});
        div_sub = rem_sh[WIDTH-1:0] - b_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    cnt_d    = '0;
                    result_d = '0;
                    hi_d     = '0;
                    carry_d  = 1'b0;
                    state_d  = S_DONE;
                    case (bus.ctl)
                        6'd32: begin
                            result_d = add_sum[WIDTH-1:0];
                            carry_d  = add_sum[WIDTH];
                        end
                        6'd34: begin
                            result_d = sub_sum[WIDTH-1:0];
                            carry_d  = sub_sum[WIDTH];
                        end
                        6'd36: result_d = bus.a & bus.b;
                        6'd37: result_d = bus.a | bus.b;
                        6'd38: result_d = bus.a ^ bus.b;
                        6'd39: result_d = ~(bus.a | bus.b);
                        6'd42: result_d = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ slt_ovf};
                        6'd43: result_d = {{(WIDTH-1){1'b0}}, ~sub_sum[WIDTH]};
                        6'd25: begin
                            result_d = bus.a;
                            b_d      = bus.b;
                            state_d  = S_MUL;
                        end
`ifdef SEQ_ALU_DIV_EN
                        6'd27: begin
                            if (bus.b == '0) begin
                                result_d = '1;
                                hi_d     = bus.a;
                            end else begin
                                result_d = bus.a;
                                b_d      = bus.b;
                                state_d  = S_DIV;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d    = cnt_q + 1'b1;
                hi_d     = mul_sum[WIDTH:1];
                result_d = {mul_sum[0], result_q[WIDTH-1:1]};
                if (cnt_d == CNT_DONE) begin
                    state_d = S_DONE;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
                cnt_d    = cnt_q + 1'b1;
                hi_d     = div_ge ? div_sub : rem_sh[WIDTH-1:0];
                result_d = {result_q[WIDTH-2:0], div_ge};
                if (cnt_d == CNT_DONE) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, multi-cycle corner sequences, random vs. arithmetic model.
// Latency measured from the accept edge until out_valid is seen.
// Exercises back-pressure, reset mid-operation and single-cycle throughput.
module tb_seq_alu;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   tot_cnt;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_res;
        logic [31:0] exp_hi;
        logic        exp_carry;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        carry;
        int          lat;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tot_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Reference behaviour from the arithmetic definition of each function code.
    function automatic exp_t model(input logic [5:0] c, input logic [31:0] av,
                                   input logic [31:0] bv, input logic ci);
        exp_t        e;
        logic [32:0] s;
        logic [63:0] p;
        e.res = 32'd0; e.hi = 32'd0; e.carry = 1'b0; e.lat = 1;
        case (c)
            6'd32: begin s = {1'b0, av} + {1'b0, bv} + {32'd0, ci}; e.res = s[31:0]; e.carry = s[32]; end
            6'd34: begin e.res = av - bv; e.carry = (av >= bv); end
            6'd36: e.res = av & bv;
            6'd37: e.res = av | bv;
            6'd38: e.res = av ^ bv;
            6'd39: e.res = ~(av | bv);
            6'd42: e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            6'd43: e.res = (av < bv) ? 32'd1 : 32'd0;
            6'd25: begin p = {32'd0, av} * {32'd0, bv}; e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33; end
`ifdef SEQ_ALU_DIV_EN
            6'd27: begin
                if (bv == 32'd0) begin e.res = 32'hFFFFFFFF; e.hi = av; end
                else begin e.res = av / bv; e.hi = av % bv; e.lat = 33; end
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!bus.in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, " in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    task automatic run_op(input logic [5:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic [31:0] er, input logic [31:0] eh,
                          input logic ec, input int el, input string tag);
        int lat;
        wait_ready(tag);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.ctl = c; bus.a = av; bus.b = bv; bus.cin = ci;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, " result"}, {32'd0, bus.result}, {32'd0, er});
        chk({tag, " hi"},     {32'd0, bus.hi},     {32'd0, eh});
        chk({tag, " carry"},  {63'd0, bus.carry},  {63'd0, ec});
        chk({tag, " zero"},   {63'd0, bus.zero},   {63'd0, (er == 32'd0)});
        chk({tag, " latency"}, 64'(lat), 64'(el));
    endtask

    initial begin
        vec_t  vecs[$];
        int    lat_div, vcnt;
        logic [31:0] dr, dh, d0r, d0h;
        logic [5:0]  codes [11];
        exp_t  e;
        logic [5:0]  rc;
        logic [31:0] ra, rb;
        logic        rci;

        pass_cnt = 0; tot_cnt = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.ctl = 6'd0; bus.a = 32'd0; bus.b = 32'd0;
        bus.cin = 1'b0; bus.out_ready = 1'b1;

`ifdef SEQ_ALU_DIV_EN
        dr = 32'd14; dh = 32'd2; lat_div = 33; d0r = 32'hFFFFFFFF; d0h = 32'd9;
`else
        dr = 32'd0; dh = 32'd0; lat_div = 1; d0r = 32'd0; d0h = 32'd0;
`endif
        vecs.push_back('{6'd32, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 32'd0, 1'b1, 1});
        vecs.push_back('{6'd32, 32'd1, 32'd2, 1'b1, 32'd4, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd34, 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd34, 32'd7, 32'd5, 1'b0, 32'd2, 32'd0, 1'b1, 1});
        vecs.push_back('{6'd36, 32'hF0, 32'h3C, 1'b0, 32'h30, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd37, 32'hF0, 32'h0F, 1'b0, 32'hFF, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd38, 32'hFF, 32'h0F, 1'b0, 32'hF0, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd39, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd42, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'd0, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd43, 32'h7FFFFFFF, 32'h80000000, 1'b0, 32'd1, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd42, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd1, 32'd0, 1'b0, 1});
        vecs.push_back('{6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h1, 32'hFFFFFFFE, 1'b0, 33});
        vecs.push_back('{6'd25, 32'd6, 32'd7, 1'b0, 32'd42, 32'd0, 1'b0, 33});
        vecs.push_back('{6'd27, 32'd100, 32'd7, 1'b0, dr, dh, 1'b0, lat_div});
        vecs.push_back('{6'd27, 32'd9, 32'd0, 1'b0, d0r, d0h, 1'b0, 1});
        vecs.push_back('{6'd0, 32'd5, 32'd3, 1'b1, 32'd0, 32'd0, 1'b0, 1});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst result",    {32'd0, bus.result},    64'd0);
        chk("rst hi",        {32'd0, bus.hi},        64'd0);
        chk("rst carry",     {63'd0, bus.carry},     64'd0);
        chk("rst zero",      {63'd0, bus.zero},      64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_res,
                   vecs[i].exp_hi, vecs[i].exp_carry, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a multiply aborts it
        wait_ready("abort");
        bus.in_valid = 1'b1; bus.ctl = 6'd25; bus.a = 32'd123; bus.b = 32'd456;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("abort result",    {32'd0, bus.result},    64'd0);
        chk("abort zero",      {63'd0, bus.zero},      64'd1);
        chk("abort in_ready",  {63'd0, bus.in_ready},  64'd1);
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vcnt++;
        end
        chk("abort no result", 64'(vcnt), 64'd0);

        // Back-pressure: result held, new requests ignored until handshake
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.ctl = 6'd36; bus.a = 32'hF0; bus.b = 32'h3C;
        @(posedge clk); #1;
        bus.ctl = 6'd37; bus.a = 32'h12345678; bus.b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp result",    {32'd0, bus.result},    64'h30);
            chk("bp in_ready",  {63'd0, bus.in_ready},  64'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("bp release in_ready",  {63'd0, bus.in_ready},  64'd1);
        @(posedge clk); #1;
        chk("bp ignored out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Throughput: one single-cycle op every two cycles
        bus.in_valid = 1'b1; bus.ctl = 6'd32; bus.a = 32'd1; bus.b = 32'd1; bus.cin = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) vcnt++;
        end
        bus.in_valid = 1'b0;
        chk("throughput", 64'(vcnt), 64'd10);

        // Random stimulus against the model
        codes = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd25, 6'd27, 6'd0};
        for (int i = 0; i < 150; i++) begin
            rc = codes[$urandom_range(0, 10)];
            if (rc == 6'd0) rc = 6'($urandom_range(0, 63));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFFFFFF;
            rci = 1'($urandom_range(0, 1));
            e = model(rc, ra, rb, rci);
            run_op(rc, ra, rb, rci, e.res, e.hi, e.carry, e.lat, $sformatf("rnd%0d ctl%0d", i, rc));
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle integer ALU for the datapath execute stage, generalising the 32-bit combinational ALU to WIDTH bits. Single-cycle ops are registered; unsigned multiply and divide iterate over WIDTH cycles. A valid/ready handshake sits on both sides so the core can stall on long ops.

## Interface
- WIDTH, 32: operand/result width in bits; integer ≥ 4.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request; high only in IDLE
- ctl  in  6  function code (MIPS funct encoding)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in, used by add only
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  primary result (LO for mult/div)
- hi  out  WIDTH  high half of product / remainder; 0 for other ops
- carry  out  1  carry-out of add/sub; 0 for other ops
- zero  out  1  result == 0

## Operation
- Request accepted when in_valid && in_ready; a, b, ctl, cin captured.
- ctl codes: 32 add = a+b+cin; 34 sub = a+~b+1 (cin ignored); 36 and; 37 or; 38 xor; 39 nor; 42 slt signed (correct under overflow: sign XOR overflow); 43 sltu (borrow of a-b); 25 multu; 27 divu. slt/sltu give {0…,bit}.
- Any other ctl: result 0, hi 0, carry 0, zero 1; completes as a single-cycle op.
- States: IDLE → (single-cycle op) DONE; IDLE → (25) MUL; IDLE → (27, b≠0) DIV; IDLE → (27, b==0) DONE; MUL/DIV → DONE after WIDTH iterations; DONE → IDLE when out_ready.
- MUL: unsigned shift-add, one multiplier bit per cycle; {hi,result} = a*b, 2·WIDTH bits exact.
- DIV: restoring, one quotient bit per cycle; result = a/b, hi = a%b.
- Divide by zero: result all ones, hi = a, carry 0.
- Iteration counter width = clog2(WIDTH+1); stops at exactly WIDTH.
- Outputs held stable while out_valid && !out_ready.

## Timing
- Reset (rst_n low at edge): state IDLE, in_ready 1, out_valid 0, result 0, hi 0, carry 0, zero 1, counter 0. Reset mid-MUL/DIV aborts; no result emitted.
- Latency accept→out_valid: single-cycle ops and div-by-zero 1 cycle; multu/divu WIDTH+1 cycles.
- out_valid rises in DONE; handshake completes on edge with out_valid && out_ready; in_ready high the following cycle (no same-cycle accept in DONE).
- Throughput: one single-cycle op per 2 cycles with out_ready held high.
- Inputs ignored when in_ready low; in_valid may drop without effect in non-IDLE states.

## Configuration
- SEQ_ALU_DIV_EN defined: ctl 27 (divu) implemented as above.
- Undefined: DIV state and divider datapath removed; ctl 27 treated as unsupported code (result 0, hi 0, 1-cycle latency).

## Test plan
- Reset: hold rst_n low 2 cycles during an active multu → out_valid 0, result 0, zero 1, in_ready 1 next cycle.
- add a=0xFFFFFFFF, b=1, cin=0 → result 0, carry 1, zero 1 after 1 cycle; sub a=5, b=7 → 0xFFFFFFFE, carry 0.
- slt a=0x7FFFFFFF, b=0x80000000 → 0 (overflow-corrected); sltu same operands → 1.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi 0xFFFFFFFE, result 0x00000001, out_valid exactly 33 cycles after accept.
- divu a=100, b=7 → result 14, hi 2 after 33 cycles; divu b=0, a=9 → result 0xFFFFFFFF, hi 9 after 1 cycle; with SEQ_ALU_DIV_EN undefined → result 0.
- Back-pressure: out_ready low 5 cycles after and a=0xF0, b=0x3C → result 0x30 held stable, in_ready 0, new in_valid ignored until handshake.
